// File: rtl/playback_pkg.sv
// Shared types and constants for the flash audio playback sequencer.
// Covers the FSM state encoding, bus widths and default sample region.
package playback_pkg;

    localparam int unsigned ADDR_W   = 23;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned BE_W     = 4;

    localparam logic [BE_W-1:0]   BYTEEN_ALL     = 4'hF;
    localparam logic [ADDR_W-1:0] DEF_START_ADDR = 23'h0;
    localparam logic [ADDR_W-1:0] DEF_END_ADDR   = 23'h7FFFF;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        EMIT1,
        HOLD,
        EMIT2
    } state_t;

    // Select one 16-bit half of a flash word: hi=1 gives [31:16].
    function automatic logic [SAMPLE_W-1:0] pick_half(input logic [WORD_W-1:0] word,
                                                      input logic              hi);
        return hi ? word[WORD_W-1 -: SAMPLE_W] : word[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/flash_addr_counter.sv
// Bidirectional word-address counter that wraps inside [START_ADDR, END_ADDR].
// Load jumps to the traversal start for the given direction and has priority over step.
module flash_addr_counter
    import playback_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_dir,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= START_ADDR;
        end else if (i_load) begin
            r_addr <= i_dir ? END_ADDR : START_ADDR;
        end else if (i_step) begin
            if (!i_dir) begin
                r_addr <= (r_addr == END_ADDR) ? START_ADDR : r_addr + ADDR_W'(1);
            end else begin
                r_addr <= (r_addr == START_ADDR) ? END_ADDR : r_addr - ADDR_W'(1);
            end
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/flash_playback_sequencer.sv
// Fetches one 32-bit flash word per sample tick over Avalon-MM and plays its
// two 16-bit halves on successive ticks, with direction, pause and restart.
module flash_playback_sequencer
    import playback_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                dir,
    input  logic                restart,
    output logic                flash_mem_read,
    input  logic                flash_mem_waitrequest,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [BE_W-1:0]     flash_mem_byteenable,
    input  logic [WORD_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_sample,
    output logic                sample_valid,
    output logic                busy
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_restart_pend;
    logic                w_restart;
    logic                w_fire;
    logic                w_cap;
    logic                w_emit2;
    logic                w_step;
    logic                w_cnt_dir;
    logic [WORD_W-1:0]   r_word_q;
    logic                r_dir_q;
    logic                r_read;
    logic                r_busy;
    logic                r_valid;
    logic [SAMPLE_W-1:0] r_sample;
    logic [ADDR_W-1:0]   w_addr;

    // A restart pulse in the current cycle counts the same as one already pending.
    assign w_restart = restart | r_restart_pend;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_restart_pend <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_restart_pend <= w_fire ? 1'b0 : (restart ? 1'b1 : r_restart_pend);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_cap        = 1'b0;
        w_emit2      = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_restart) begin
                    w_fire = 1'b1;
                end else if (sample_tick && play) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (!flash_mem_waitrequest) begin
                    w_next_state = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // Restart discards the returned word rather than aborting the read.
                if (flash_mem_readdatavalid) begin
                    if (w_restart) begin
                        w_fire       = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_cap        = 1'b1;
                        w_next_state = EMIT1;
                    end
                end
            end
            EMIT1: begin
                w_next_state = HOLD;
            end
            HOLD: begin
                if (w_restart) begin
                    w_fire       = 1'b1;
                    w_next_state = IDLE;
                end else if (sample_tick && play) begin
                    w_emit2      = 1'b1;
                    w_next_state = EMIT2;
                end
            end
            EMIT2: begin
                w_next_state = IDLE;
                if (w_restart) begin
                    w_fire = 1'b1;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_read   <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_word_q <= '0;
            r_dir_q  <= 1'b0;
        end else begin
            r_read  <= (w_next_state == REQ);
            r_busy  <= (w_next_state == REQ) || (w_next_state == WAIT_DATA);
            r_valid <= w_cap || w_emit2;
            if (w_cap) begin
                r_word_q <= flash_mem_readdata;
                r_dir_q  <= dir;
                r_sample <= pick_half(flash_mem_readdata, dir);
            end else if (w_emit2) begin
                r_sample <= pick_half(r_word_q, !r_dir_q);
            end
        end
    end

    // Restart loads with the live direction; a normal step uses the captured one.
    assign w_cnt_dir = w_fire ? dir : r_dir_q;

    flash_addr_counter #(
        .START_ADDR(START_ADDR),
        .END_ADDR  (END_ADDR)
    ) u_addr_cnt (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .i_load(w_fire),
        .i_step(w_step),
        .i_dir (w_cnt_dir),
        .o_addr(w_addr)
    );

    assign flash_mem_read       = r_read;
    assign flash_mem_address    = w_addr;
    assign flash_mem_byteenable = BYTEEN_ALL;
    assign audio_sample         = r_sample;
    assign sample_valid         = r_valid;
    assign busy                 = r_busy;

endmodule

// File: tb/tb_flash_playback_sequencer.sv
// Bench for flash_playback_sequencer: directed scenarios plus a randomized run
// scored against a word/sample stream model with an Avalon slave responder.
module tb_flash_playback_sequencer;

    localparam logic [22:0] S_ADDR = 23'h0;
    localparam logic [22:0] E_ADDR = 23'h7FFFF;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        sample_tick;
    logic        play;
    logic        dir;
    logic        restart;
    logic        flash_mem_read;
    logic        flash_mem_waitrequest;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic        busy;

    flash_playback_sequencer dut (
        .CLOCK_50               (CLOCK_50),
        .reset_n                (reset_n),
        .sample_tick            (sample_tick),
        .play                   (play),
        .dir                    (dir),
        .restart                (restart),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_mem_readdata     (flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .audio_sample           (audio_sample),
        .sample_valid           (sample_valid),
        .busy                   (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_total = 0;
    int n_bad   = 0;

    // slave configuration and state
    bit          cfg_force = 1'b1;
    bit          cfg_rand  = 1'b0;
    logic [31:0] cfg_data  = 32'h0;
    int          cfg_stall = 0;
    int          cfg_dly   = 0;
    bit          s_pending = 1'b0;
    bit          s_in_req  = 1'b0;
    int          s_stall   = 0;
    int          s_dly     = 0;
    int          s_acc     = 0;
    logic [22:0] s_addr    = 23'h0;

    // scoreboard
    typedef struct {
        logic [15:0] s;
        bit          last;
        bit          d;
    } exp_t;
    exp_t        q[$];
    bit          sb_en      = 1'b0;
    logic [22:0] model_addr = 23'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        return {a[15:0] ^ 16'h5A5A, a[22:7] ^ 16'h0F0F};
    endfunction

    function automatic logic [22:0] next_addr(input logic [22:0] a, input bit d);
        if (!d) return (a == E_ADDR) ? S_ADDR : a + 23'd1;
        return (a == S_ADDR) ? E_ADDR : a - 23'd1;
    endfunction

    task automatic slave_step();
        flash_mem_readdatavalid = 1'b0;
        if (s_pending) begin
            if (s_dly == 0) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata      = cfg_force ? cfg_data : mem_word(s_addr);
                s_pending               = 1'b0;
            end else begin
                s_dly--;
            end
        end
        if (flash_mem_read) begin
            if (!s_in_req) begin
                s_in_req = 1'b1;
                s_stall  = cfg_rand ? int'($urandom_range(0, 3)) : cfg_stall;
            end
            if (s_stall > 0) begin
                flash_mem_waitrequest = 1'b1;
                s_stall--;
            end else begin
                flash_mem_waitrequest = 1'b0;
                s_pending = 1'b1;
                s_addr    = flash_mem_address;
                s_dly     = cfg_rand ? int'($urandom_range(0, 3)) : cfg_dly;
                s_acc++;
                s_in_req  = 1'b0;
                if (sb_en) chk("rd_addr", 32'(flash_mem_address), 32'(model_addr));
            end
        end else begin
            flash_mem_waitrequest = 1'($urandom);
            s_in_req = 1'b0;
        end
    endtask

    // One cycle: strobes drop, the slave reacts, outputs are stable for checking.
    task automatic cyc();
        @(negedge CLOCK_50);
        sample_tick = 1'b0;
        restart     = 1'b0;
        slave_step();
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc();
            seen = sample_valid;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic run_word(input logic [22:0] rd_a, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [22:0] a_after);
        sample_tick = 1'b1;
        cyc();
        chk("rw_read", 32'(flash_mem_read), 32'd1);
        chk("rw_addr", 32'(flash_mem_address), 32'(rd_a));
        wait_valid("rw_valid1");
        chk("rw_s1", 32'(audio_sample), 32'(e1));
        cyc();
        sample_tick = 1'b1;
        cyc();
        chk("rw_valid2", 32'(sample_valid), 32'd1);
        chk("rw_s2", 32'(audio_sample), 32'(e2));
        cyc();
        chk("rw_addr_after", 32'(flash_mem_address), 32'(a_after));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc0;
        bit fwd_seen;
        reset_n = 1'b0; sample_tick = 1'b0; play = 1'b0; dir = 1'b0; restart = 1'b0;
        flash_mem_waitrequest = 1'b1; flash_mem_readdata = 32'h0; flash_mem_readdatavalid = 1'b0;

        // reset state
        do_reset();
        chk("rst_read",  32'(flash_mem_read), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample", 32'(audio_sample), 32'd0);
        chk("rst_addr",  32'(flash_mem_address), 32'(S_ADDR));
        chk("byteen",    32'(flash_mem_byteenable), 32'hF);

        // forward basic with exact latency
        play = 1'b1; dir = 1'b0; cfg_data = 32'hBEEF_1234;
        cyc();
        sample_tick = 1'b1;
        cyc();
        chk("fb_read", 32'(flash_mem_read), 32'd1);
        chk("fb_busy", 32'(busy), 32'd1);
        chk("fb_addr", 32'(flash_mem_address), 32'd0);
        cyc();
        chk("fb_read_drop", 32'(flash_mem_read), 32'd0);
        chk("fb_busy_wait", 32'(busy), 32'd1);
        cyc();
        chk("fb_valid1", 32'(sample_valid), 32'd1);
        chk("fb_s1", 32'(audio_sample), 32'h1234);
        cyc();
        chk("fb_valid_pulse", 32'(sample_valid), 32'd0);
        chk("fb_hold_sample", 32'(audio_sample), 32'h1234);
        chk("fb_addr_hold", 32'(flash_mem_address), 32'd0);
        sample_tick = 1'b1;
        cyc();
        chk("fb_valid2", 32'(sample_valid), 32'd1);
        chk("fb_s2", 32'(audio_sample), 32'hBEEF);
        cyc();
        chk("fb_addr_step", 32'(flash_mem_address), 32'd1);

        // backpressure: 5 stalled cycles, ticks dropped, one transaction
        cfg_stall = 5; cfg_data = 32'hCAFE_0001; acc0 = s_acc;
        sample_tick = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_read", 32'(flash_mem_read), 32'd1);
            chk("bp_addr", 32'(flash_mem_address), 32'd1);
            sample_tick = 1'b1;
            cyc();
        end
        wait_valid("bp_valid1");
        chk("bp_s1", 32'(audio_sample), 32'h0001);
        cyc();
        sample_tick = 1'b1;
        cyc();
        chk("bp_s2", 32'(audio_sample), 32'hCAFE);
        repeat (3) cyc();
        chk("bp_one_txn", 32'(s_acc - acc0), 32'd1);
        chk("bp_addr_after", 32'(flash_mem_address), 32'd2);
        cfg_stall = 0;

        // wrap: restart backward loads END, then forward wraps to START
        dir = 1'b1; restart = 1'b1;
        cyc();
        cyc();
        chk("wr_load_end", 32'(flash_mem_address), 32'(E_ADDR));
        dir = 1'b0; cfg_data = 32'h1111_2222;
        run_word(E_ADDR, 16'h2222, 16'h1111, S_ADDR);
        dir = 1'b1; cfg_data = 32'h3333_4444;
        run_word(S_ADDR, 16'h3333, 16'h4444, E_ADDR);

        // pause while holding the second half
        dir = 1'b0; cfg_data = 32'h5555_6666;
        sample_tick = 1'b1;
        wait_valid("pz_valid1");
        chk("pz_s1", 32'(audio_sample), 32'h6666);
        play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_tick = i[0];
            cyc();
            chk("pz_no_valid", 32'(sample_valid), 32'd0);
            chk("pz_no_read", 32'(flash_mem_read), 32'd0);
        end
        play = 1'b1; sample_tick = 1'b1;
        cyc();
        chk("pz_valid2", 32'(sample_valid), 32'd1);
        chk("pz_s2", 32'(audio_sample), 32'h5555);
        cyc();
        chk("pz_addr", 32'(flash_mem_address), 32'(S_ADDR));

        // restart during WAIT_DATA with dir=1: word discarded
        cfg_dly = 3; cfg_data = 32'h7777_8888;
        sample_tick = 1'b1;
        cyc();
        cyc();
        chk("rs_in_wait", 32'(busy && !flash_mem_read), 32'd1);
        dir = 1'b1; restart = 1'b1;
        fwd_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (sample_valid) fwd_seen = 1'b1;
        end
        chk("rs_no_valid", 32'(fwd_seen), 32'd0);
        chk("rs_addr_end", 32'(flash_mem_address), 32'(E_ADDR));
        chk("rs_idle", 32'(busy), 32'd0);
        cfg_dly = 0;
        run_word(E_ADDR, 16'h7777, 16'h8888, E_ADDR - 23'd1);

        // async reset mid-WAIT_DATA; late readdatavalid ignored
        cfg_dly = 4; cfg_data = 32'hDEAD_BEEF;
        sample_tick = 1'b1;
        cyc();
        cyc();
        chk("ar_in_wait", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_read", 32'(flash_mem_read), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_sample", 32'(audio_sample), 32'd0);
        chk("ar_addr", 32'(flash_mem_address), 32'(S_ADDR));
        play = 1'b0;
        cyc();
        reset_n = 1'b1;
        fwd_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (sample_valid || busy) fwd_seen = 1'b1;
        end
        chk("ar_late_rdv_ignored", 32'(fwd_seen), 32'd0);
        chk("ar_pending_drained", 32'(s_pending), 32'd0);
        play = 1'b1; cfg_dly = 0; cfg_data = 32'h9999_AAAA;
        run_word(S_ADDR, 16'h9999, 16'hAAAA, E_ADDR);

        // randomized run against the stream model
        play = 1'b0; dir = 1'b0;
        do_reset();
        cfg_force = 1'b0; cfg_rand = 1'b1; sb_en = 1'b1; model_addr = S_ADDR;
        q.delete();
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (sample_valid) begin
                chk("sb_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_sample", 32'(audio_sample), 32'(e.s));
                    if (e.last) model_addr = next_addr(model_addr, e.d);
                end
            end
            sample_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) play = ~play;
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if (flash_mem_readdatavalid && busy && !flash_mem_read) begin
                exp_t e1, e2;
                e1.s = dir ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
                e1.last = 1'b0; e1.d = dir;
                e2.s = dir ? flash_mem_readdata[15:0] : flash_mem_readdata[31:16];
                e2.last = 1'b1; e2.d = dir;
                q.push_back(e1);
                q.push_back(e2);
            end
        end
        play = 1'b1;
        for (int c = 0; c < 200 && q.size() != 0; c++) begin
            cyc();
            if (sample_valid && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_drain_sample", 32'(audio_sample), 32'(e.s));
                if (e.last) model_addr = next_addr(model_addr, e.d);
            end
            sample_tick = (c % 4 == 0);
        end
        chk("sb_drained", 32'(q.size()), 32'd0);
        repeat (3) cyc();
        chk("sb_final_addr", 32'(flash_mem_address), 32'(model_addr));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
